// File: rtl/scc_imem_pkg.sv
// Shared types and address helpers for the instruction-memory responder.
package scc_imem_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StCommit} ld_state_e;

  localparam int unsigned WORD_BYTES          = 4;
  localparam logic [31:0] FAULT_INSTR_DEFAULT = 32'h0000_0000;

  function automatic logic addr_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned idx_w);
    return (addr >> (idx_w + 2)) != 32'd0;
  endfunction

  function automatic logic ptr_out_of_range(input logic [29:0] ptr, input int unsigned idx_w);
    return (ptr >> idx_w) != 30'd0;
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words and tracks the word write pointer.
module imem_word_assembler
  import scc_imem_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [29:0] base_ptr_i,
  input  logic        active_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  input  logic        flush_i,
  output logic        wr_full_o,
  output logic        wr_flush_o,
  output logic [31:0] wr_word_o,
  output logic [29:0] ptr_o
);

  logic [1:0]  count_q, count_d;
  logic [23:0] lanes_q, lanes_d;
  logic [29:0] ptr_q, ptr_d;
  logic        take;

  assign take  = active_i && byte_valid_i;
  assign ptr_o = ptr_q;

  always_comb begin
    count_d    = count_q;
    lanes_d    = lanes_q;
    ptr_d      = ptr_q;
    wr_full_o  = take && (count_q == 2'd3);
    wr_flush_o = flush_i && (count_q != 2'd0);
    // Lanes fill bottom-up and are cleared after every write, so unused upper lanes read as zero.
    wr_word_o  = {(wr_full_o ? byte_i : 8'h00), lanes_q};
    if (start_i) begin
      ptr_d   = base_ptr_i;
      count_d = 2'd0;
      lanes_d = 24'h0;
    end else if (take) begin
      if (count_q == 2'd3) begin
        count_d = 2'd0;
        lanes_d = 24'h0;
        ptr_d   = ptr_q + 30'd1;
      end else begin
        case (count_q)
          2'd0:    lanes_d[7:0]   = byte_i;
          2'd1:    lanes_d[15:8]  = byte_i;
          default: lanes_d[23:16] = byte_i;
        endcase
        count_d = count_q + 2'd1;
      end
    end else if (flush_i) begin
      count_d = 2'd0;
      lanes_d = 24'h0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= 2'd0;
      lanes_q <= 24'h0;
      ptr_q   <= 30'd0;
    end else begin
      count_q <= count_d;
      lanes_q <= lanes_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory with a 1-cycle fetch port and a byte-stream image loader.
module imem_responder
  import scc_imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10,
  parameter logic [31:0] FAULT_INSTR = FAULT_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  output logic        fetch_ready_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_instr_o,
  output logic        rsp_fault_o,
  input  logic        ld_start_i,
  input  logic [31:0] ld_base_i,
  input  logic        ld_byte_valid_i,
  input  logic [7:0]  ld_byte_i,
  input  logic        ld_end_i,
  output logic        ld_busy_o,
  output logic        ld_done_o,
  output logic        ld_err_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  ld_state_e   state_q;
  logic        ld_busy_q, ld_done_q, ld_err_q;
  logic        rsp_valid_q, rsp_fault_q;
  logic [31:0] rsp_instr_q;

  logic        wr_full, wr_flush, wr_any, wr_en, wr_drop;
  logic [31:0] wr_word;
  logic [29:0] wr_ptr;
  logic        fetch_accept, fetch_fault;
  logic [IDX_W-1:0] fetch_idx;
  logic        unused_base;

  assign unused_base = ^ld_base_i[1:0];

  imem_word_assembler u_asm (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      ((state_q == StIdle) && ld_start_i),
    .base_ptr_i   (ld_base_i[31:2]),
    .active_i     (state_q == StLoad),
    .byte_valid_i (ld_byte_valid_i),
    .byte_i       (ld_byte_i),
    .flush_i      (state_q == StCommit),
    .wr_full_o    (wr_full),
    .wr_flush_o   (wr_flush),
    .wr_word_o    (wr_word),
    .ptr_o        (wr_ptr)
  );

  assign wr_any  = wr_full || wr_flush;
  assign wr_en   = wr_any && !ptr_out_of_range(wr_ptr, IDX_W);
  assign wr_drop = wr_any && ptr_out_of_range(wr_ptr, IDX_W);

  // Combinational so a same-cycle ld_start blocks the fetch.
  assign fetch_ready_o = (state_q == StIdle) && !ld_start_i;
  assign fetch_accept  = fetch_req_i && fetch_ready_o;
  assign fetch_idx     = fetch_addr_i[IDX_W+1:2];
  assign fetch_fault   = addr_misaligned(fetch_addr_i) || addr_out_of_range(fetch_addr_i, IDX_W);

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr[IDX_W-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= 32'h0;
      rsp_fault_q <= 1'b0;
    end else begin
      rsp_valid_q <= fetch_accept;
      if (fetch_accept) begin
        rsp_fault_q <= fetch_fault;
        rsp_instr_q <= fetch_fault ? FAULT_INSTR : mem_q[fetch_idx];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      ld_busy_q <= 1'b0;
      ld_done_q <= 1'b0;
      ld_err_q  <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      if (wr_drop) begin
        ld_err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (ld_start_i) begin
            state_q   <= StLoad;
            ld_busy_q <= 1'b1;
            ld_err_q  <= 1'b0;
          end
        end
        StLoad: begin
          if (ld_end_i) begin
            state_q <= StCommit;
          end
        end
        StCommit: begin
          state_q   <= StIdle;
          ld_busy_q <= 1'b0;
          ld_done_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_instr_o = rsp_instr_q;
  assign rsp_fault_o = rsp_fault_q;
  assign ld_busy_o   = ld_busy_q;
  assign ld_done_o   = ld_done_q;
  assign ld_err_o    = ld_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scenario bench for imem_responder: expected fetch responses are queued and checked on arrival.
module tb_imem_responder;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic        fetch_ready;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic        rsp_fault;
  logic        ld_start = 1'b0;
  logic [31:0] ld_base = 32'h0;
  logic        ld_byte_valid = 1'b0;
  logic [7:0]  ld_byte = 8'h0;
  logic        ld_end = 1'b0;
  logic        ld_busy, ld_done, ld_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  imem_responder dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .fetch_req_i     (fetch_req),
    .fetch_addr_i    (fetch_addr),
    .fetch_ready_o   (fetch_ready),
    .rsp_valid_o     (rsp_valid),
    .rsp_instr_o     (rsp_instr),
    .rsp_fault_o     (rsp_fault),
    .ld_start_i      (ld_start),
    .ld_base_i       (ld_base),
    .ld_byte_valid_i (ld_byte_valid),
    .ld_byte_i       (ld_byte),
    .ld_end_i        (ld_end),
    .ld_busy_o       (ld_busy),
    .ld_done_o       (ld_done),
    .ld_err_o        (ld_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every response must match the head of the queue, including its arrival cycle.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 instr=%h at cycle %0d, required no response",
                 rsp_instr, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc !== cyc || rsp_instr !== mon_e.instr || rsp_fault !== mon_e.fault) begin
          errors++;
          $display("FAIL rsp: got instr=%h fault=%b cycle=%0d, required instr=%h fault=%b cycle=%0d",
                   rsp_instr, rsp_fault, cyc, mon_e.instr, mon_e.fault, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_push(input logic [31:0] addr, input logic [31:0] instr, input logic fault);
    sb.push_back('{cyc + 1, instr, fault});
    fetch_req  = 1'b1;
    fetch_addr = addr;
  endtask

  task automatic do_load(input logic [31:0] base, input logic [7:0] b [8], input int n,
                         output int done_cnt, output logic busy_seen);
    done_cnt = 0;
    ld_start = 1'b1;
    ld_base  = base;
    tick();
    ld_start  = 1'b0;
    busy_seen = ld_busy;
    for (int i = 0; i < n; i++) begin
      ld_byte_valid = 1'b1;
      ld_byte       = b[i];
      tick();
      if (ld_done === 1'b1) done_cnt++;
    end
    ld_byte_valid = 1'b0;
    ld_end        = 1'b1;
    tick();
    ld_end = 1'b0;
    repeat (4) begin
      tick();
      if (ld_done === 1'b1) done_cnt++;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({rsp_valid, rsp_fault, ld_busy, ld_done, ld_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid/fault/busy/done/err=%b, required 00000",
               {rsp_valid, rsp_fault, ld_busy, ld_done, ld_err});
    end
    checks++;
    if (rsp_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_instr: got %h, required 00000000", rsp_instr);
    end
    checks++;
    if (fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", fetch_ready);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load();
    logic [7:0] b [8];
    int         dn;
    logic       bs;
    b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_load(32'h0, b, 8, dn, bs);
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL load_done: got %0d pulses, required 1", dn);
    end
    checks++;
    if (bs !== 1'b1 || ld_busy !== 1'b0) begin
      errors++;
      $display("FAIL load_busy: got during=%b after=%b, required during=1 after=0", bs, ld_busy);
    end
    checks++;
    if (ld_err !== 1'b0) begin
      errors++;
      $display("FAIL load_err: got %b, required 0", ld_err);
    end
    fetch_push(32'h0, 32'h1234_5678, 1'b0);
    tick();
    fetch_push(32'h4, 32'hDEAD_BEEF, 1'b0);
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_partial();
    logic [7:0] b [8];
    int         dn;
    logic       bs;
    b = '{8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_load(32'h8, b, 2, dn, bs);
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL partial_done: got %0d pulses, required 1", dn);
    end
    fetch_push(32'h8, 32'h0000_BBAA, 1'b0);
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    fetch_push(32'h0, 32'h1234_5678, 1'b0);
    tick();
    fetch_push(32'h4, 32'hDEAD_BEEF, 1'b0);
    tick();
    fetch_push(32'h8, 32'h0000_BBAA, 1'b0);
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL stream_drain: got %0d responses missing, required 0", sb.size());
    end
  endtask

  task automatic test_faults();
    logic [7:0] b [8];
    int         dn;
    logic       bs;
    fetch_push(32'h2, 32'h0, 1'b1);
    tick();
    fetch_push(4 * DEPTH, 32'h0, 1'b1);
    tick();
    fetch_req = 1'b0;
    tick();
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_load(4 * (DEPTH - 1), b, 8, dn, bs);
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL oob_done: got %0d pulses, required 1", dn);
    end
    checks++;
    if (ld_err !== 1'b1) begin
      errors++;
      $display("FAIL oob_err: got %b, required 1", ld_err);
    end
    fetch_push(4 * (DEPTH - 1), 32'h0403_0201, 1'b0);
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_arbitration();
    logic [7:0] b [4];
    int         found;
    b          = '{8'h11, 8'h22, 8'h33, 8'h44};
    found      = 0;
    ld_start   = 1'b1;
    ld_base    = 32'hC;
    fetch_req  = 1'b1;
    fetch_addr = 32'hC;
    #1;
    checks++;
    if (fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL arb_ready: got %b, required 0", fetch_ready);
    end
    tick();
    ld_start = 1'b0;
    checks++;
    if (ld_busy !== 1'b1 || ld_err !== 1'b0) begin
      errors++;
      $display("FAIL arb_busy: got busy=%b err=%b, required busy=1 err=0", ld_busy, ld_err);
    end
    // A second ld_start mid-session must not move the pointer.
    for (int i = 0; i < 4; i++) begin
      ld_start      = (i == 2);
      ld_base       = (i == 2) ? 32'h100 : 32'hC;
      ld_byte_valid = 1'b1;
      ld_byte       = b[i];
      tick();
    end
    ld_start      = 1'b0;
    ld_byte_valid = 1'b0;
    ld_end        = 1'b1;
    tick();
    ld_end = 1'b0;
    for (int i = 0; i < 5 && found == 0; i++) begin
      tick();
      if (ld_done === 1'b1) begin
        found = 1;
        sb.push_back('{cyc + 1, 32'h4433_2211, 1'b0});
        tick();
        fetch_req = 1'b0;
      end
    end
    fetch_req = 1'b0;
    checks++;
    if (found != 1) begin
      errors++;
      $display("FAIL arb_done: got ld_done seen=%0d, required 1", found);
    end
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL arb_drain: got %0d responses missing, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] b [8];
    int         dn;
    logic       bs;
    b = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    do_load(32'h10, b, 8, dn, bs);
    fetch_push(32'h10, 32'h1413_1211, 1'b0);
    tick();
    fetch_req = 1'b0;
    tick();
    ld_start = 1'b1;
    ld_base  = 32'h10;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ld_byte_valid = 1'b1;
      ld_byte       = 8'hA0 + 8'(i);
      tick();
    end
    ld_byte_valid = 1'b0;
    reset = 1'b1;
    #2;
    checks++;
    if ({rsp_valid, rsp_fault, ld_busy, ld_done, ld_err} !== 5'b0 || rsp_instr !== 32'h0) begin
      errors++;
      $display("FAIL midload_reset: got flags=%b instr=%h, required flags=00000 instr=00000000",
               {rsp_valid, rsp_fault, ld_busy, ld_done, ld_err}, rsp_instr);
    end
    tick();
    reset = 1'b0;
    dn = 0;
    repeat (4) begin
      tick();
      if (ld_done !== 1'b0 || ld_busy !== 1'b0) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL midload_nodone: got %0d cycles with done/busy set, required 0", dn);
    end
    fetch_push(32'h10, 32'hA3A2_A1A0, 1'b0);
    tick();
    fetch_push(32'h14, 32'h1817_1615, 1'b0);
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL midload_drain: got %0d responses missing, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_partial();
    test_back_to_back();
    test_faults();
    test_arbitration();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
